// File: rtl/arith_shift_pkg.sv
// Shared types and width helpers for the pipelined signed right-shift / divide-by-2^k unit.
package arith_shift_pkg;

  typedef enum logic {
    ASH_FLOOR = 1'b0,
    ASH_TRUNC = 1'b1
  } ash_mode_t;

  function automatic int shamt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage: conditional arithmetic right shift by the fixed amount SH.
// Optional sticky/inexact carry is present when ARITH_SHIFT_INEXACT_FLAG_EN is defined.
module shift_pipe_stage
  import arith_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_vld,
  input  logic [N-1:0]           in_data,
  input  logic [shamt_w(N)-1:0]  in_shamt,
  input  logic                   in_sat,
`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
  input  logic                   in_sticky,
  output logic                   out_sticky,
`endif
  output logic                   out_vld,
  output logic [N-1:0]           out_data,
  output logic [shamt_w(N)-1:0]  out_shamt,
  output logic                   out_sat
);

  localparam int SW  = shamt_w(N);
  localparam int SEL = $clog2(SH);

  // Sign fill built from a slice and a replicated MSB.
  function automatic logic signed [N-1:0] asr_fixed(input logic signed [N-1:0] x);
    return {{SH{x[N-1]}}, x[N-1:SH]};
  endfunction

  logic                 vld_d,   vld_q;
  logic signed [N-1:0]  data_d,  data_q;
  logic [SW-1:0]        shamt_d, shamt_q;
  logic                 sat_d,   sat_q;
  logic signed [N-1:0]  din;

  assign din = in_data;

  always_comb begin
    vld_d   = vld_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    sat_d   = sat_q;
    if (en) begin
      vld_d   = in_vld;
      shamt_d = in_shamt;
      sat_d   = in_sat;
      data_d  = (in_shamt[SEL] && !in_sat) ? asr_fixed(din) : din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= vld_d;
    data_q  <= data_d;
    shamt_q <= shamt_d;
    sat_q   <= sat_d;
  end

`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
  logic sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (en) sticky_d = in_sticky;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign out_sticky = sticky_q;
`endif

  assign out_vld   = vld_q;
  assign out_data  = data_q;
  assign out_shamt = shamt_q;
  assign out_sat   = sat_q;

endmodule

// File: rtl/arith_shift_div_pipe.sv
// Pipelined signed right shift: floor (arithmetic shift) or truncate-toward-zero divide by 2^k.
// Define ARITH_SHIFT_INEXACT_FLAG_EN to add the down_inexact output.
module arith_shift_div_pipe
  import arith_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   up_vld,
  output logic                   up_rdy,
  input  logic [N-1:0]           up_data,
  input  logic [shamt_w(N)-1:0]  up_shamt,
  input  logic                   up_mode,
  output logic                   down_vld,
  input  logic                   down_rdy,
`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
  output logic                   down_inexact,
`endif
  output logic [N-1:0]           down_data
);

  localparam int SW  = shamt_w(N);
  localparam int LAT = 1 + $clog2(N);

  // Result for k >= N: sign fill when flooring, zero when truncating.
  function automatic logic signed [N-1:0] sat_value(input logic signed [N-1:0] x,
                                                    input ash_mode_t m);
    return (m == ASH_TRUNC) ? '0 : {N{x[N-1]}};
  endfunction

  // 2^k - 1: truncation bias for negative operands and the mask of bits shifted out.
  function automatic logic signed [N-1:0] low_mask(input logic [SW-1:0] k);
    return (N'(1) << k) - N'(1);
  endfunction

  logic                en;
  ash_mode_t           mode;
  logic                over;
  logic signed [N-1:0] op;

  logic                vld_p0_d,   vld_p0_q;
  logic signed [N-1:0] data_p0_d,  data_p0_q;
  logic [SW-1:0]       shamt_p0_d, shamt_p0_q;
  logic                sat_p0_d,   sat_p0_q;

  logic                vld_s   [LAT];
  logic signed [N-1:0] data_s  [LAT];
  logic [SW-1:0]       shamt_s [LAT];
  logic                sat_s   [LAT];

  assign en     = !down_vld || down_rdy;
  assign up_rdy = en;
  assign mode   = ash_mode_t'(up_mode);
  assign over   = (up_shamt >= SW'(N));
  assign op     = up_data;

  // Stage 0: saturation detect and truncation bias
  always_comb begin
    vld_p0_d   = vld_p0_q;
    data_p0_d  = data_p0_q;
    shamt_p0_d = shamt_p0_q;
    sat_p0_d   = sat_p0_q;
    if (en) begin
      vld_p0_d   = up_vld;
      shamt_p0_d = up_shamt;
      sat_p0_d   = over;
      if (over)
        data_p0_d = sat_value(op, mode);
      else if (mode == ASH_TRUNC && op[N-1])
        data_p0_d = op + low_mask(up_shamt);
      else
        data_p0_d = op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p0_q <= 1'b0;
    else     vld_p0_q <= vld_p0_d;
    data_p0_q  <= data_p0_d;
    shamt_p0_q <= shamt_p0_d;
    sat_p0_q   <= sat_p0_d;
  end

  assign vld_s[0]   = vld_p0_q;
  assign data_s[0]  = data_p0_q;
  assign shamt_s[0] = shamt_p0_q;
  assign sat_s[0]   = sat_p0_q;

`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
  logic sticky_p0_d, sticky_p0_q;
  logic sticky_s [LAT];

  // Inexactness depends only on the original operand, so it is resolved here and carried.
  always_comb begin
    sticky_p0_d = sticky_p0_q;
    if (en) sticky_p0_d = over ? (|up_data) : (|(op & low_mask(up_shamt)));
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_p0_q <= 1'b0;
    else     sticky_p0_q <= sticky_p0_d;
  end

  assign sticky_s[0]  = sticky_p0_q;
  assign down_inexact = sticky_s[LAT-1];
`endif

  // Stages 1..LAT-1: stage j shifts by 2^(j-1) under shamt bit j-1
  for (genvar j = 1; j < LAT; j++) begin : g_stage
    shift_pipe_stage #(
      .N  (N),
      .SH (1 << (j - 1))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_vld     (vld_s[j-1]),
      .in_data    (data_s[j-1]),
      .in_shamt   (shamt_s[j-1]),
      .in_sat     (sat_s[j-1]),
`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
      .in_sticky  (sticky_s[j-1]),
      .out_sticky (sticky_s[j]),
`endif
      .out_vld    (vld_s[j]),
      .out_data   (data_s[j]),
      .out_shamt  (shamt_s[j]),
      .out_sat    (sat_s[j])
    );
  end

  logic unused_tail;
  assign unused_tail = ^{shamt_s[LAT-1], sat_s[LAT-1]};

  assign down_vld  = vld_s[LAT-1];
  assign down_data = data_s[LAT-1];

endmodule

// File: tb/tb_arith_shift_div_pipe.sv
// Randomized and directed bench for arith_shift_div_pipe against an integer-division reference model.
module tb_arith_shift_div_pipe;

  localparam int N   = 8;
  localparam int SW  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_vld;
  logic          up_rdy;
  logic [N-1:0]  up_data;
  logic [SW-1:0] up_shamt;
  logic          up_mode;
  logic          down_vld;
  logic          down_rdy;
  logic [N-1:0]  down_data;
`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
  logic          down_inexact;
`endif

  typedef struct {
    logic [N-1:0] data;
    logic         inexact;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   acc_now;
  bit   lat_on;

  always #5 clk = ~clk;

  arith_shift_div_pipe #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .up_vld       (up_vld),
    .up_rdy       (up_rdy),
    .up_data      (up_data),
    .up_shamt     (up_shamt),
    .up_mode      (up_mode),
    .down_vld     (down_vld),
    .down_rdy     (down_rdy),
`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
    .down_inexact (down_inexact),
`endif
    .down_data    (down_data)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // floor(x/2^k) or trunc(x/2^k) from plain integer division
  function automatic int ref_q(input int x, input int k, input bit trunc);
    int p;
    int q;
    p = 1 << k;
    q = x / p;
    if (!trunc && x < 0 && (x % p) != 0) q = q - 1;
    return q;
  endfunction

  function automatic bit ref_inexact(input int x, input int k);
    return ((x % (1 << k)) != 0);
  endfunction

  // Called just after a negedge with inputs set; scores the coming posedge, returns at next negedge.
  task automatic tick();
    exp_t e;
    int   x;
    #1;
    acc_now = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      if (down_vld && down_rdy) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("data", int'(down_data), int'(e.data));
`ifdef ARITH_SHIFT_INEXACT_FLAG_EN
          chk("inexact", int'(down_inexact), int'(e.inexact));
`endif
          if (lat_on) chk("latency", cyc - e.cyc, LAT);
          n_out++;
        end
      end
      if (up_vld && up_rdy) begin
        x         = int'($signed(up_data));
        e.data    = N'(ref_q(x, int'(up_shamt), up_mode));
        e.inexact = ref_inexact(x, int'(up_shamt));
        e.cyc     = cyc;
        sb.push_back(e);
        acc_now = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    up_vld   = 1'b0;
    down_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  logic [N-1:0] dd [11] = '{8'h96, 8'h96, 8'h7F, 8'h7F, 8'h08, 8'h08, 8'h80, 8'h80, 8'h80, 8'h55, 8'h55};
  int           kk [11] = '{3, 3, 2, 2, 3, 3, 7, 8, 15, 0, 0};
  bit           mm [11] = '{0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 1};

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int out0;
    rst      = 1'b1;
    up_vld   = 1'b0;
    up_data  = '0;
    up_shamt = '0;
    up_mode  = 1'b0;
    down_rdy = 1'b1;
    lat_on   = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_down_vld", int'(down_vld), 0);
    chk("rst_up_rdy", int'(up_rdy), 1);

    // Directed vectors, back to back, no stalls
    lat_on = 1'b1;
    for (int i = 0; i < 11; i++) begin
      up_vld   = 1'b1;
      up_data  = dd[i];
      up_shamt = SW'(kk[i]);
      up_mode  = mm[i];
      tick();
      chk("dir_accept", int'(acc_now), 1);
    end
    drain();
    lat_on = 1'b0;

    // Backpressure: 6 inputs against a stalled sink
    out0     = n_out;
    sent     = 0;
    down_rdy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      up_vld   = (sent < 6);
      up_data  = N'(8'h91 + 8'(sent * 13));
      up_shamt = SW'(sent % 5);
      up_mode  = sent[0];
      tick();
      if (acc_now) sent++;
    end
    chk("bp_up_rdy", int'(up_rdy), 0);
    chk("bp_down_vld", int'(down_vld), 1);
    chk("bp_accepted", sent, LAT);
    down_rdy = 1'b1;
    for (int c = 0; c < 20 && sent < 6; c++) begin
      up_vld   = 1'b1;
      up_data  = N'(8'h91 + 8'(sent * 13));
      up_shamt = SW'(sent % 5);
      up_mode  = sent[0];
      tick();
      if (acc_now) sent++;
    end
    drain();
    chk("bp_out_count", n_out - out0, 6);

    // Random traffic with random sink stalls
    out0 = n_out;
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      up_vld   = ($urandom_range(0, 3) != 0);
      up_data  = N'($urandom);
      up_shamt = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(8, 15)) : SW'($urandom_range(0, 7));
      up_mode  = 1'($urandom);
      down_rdy = ($urandom_range(0, 9) < 7);
      tick();
      if (acc_now) sent++;
    end
    chk("rnd_sent", sent, 1000);
    drain();
    chk("rnd_out_count", n_out - out0, 1000);

    // Reset with three transactions in flight
    down_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up_vld   = 1'b1;
      up_data  = N'(8'h40 + 8'(i));
      up_shamt = SW'(i);
      up_mode  = 1'b0;
      tick();
    end
    up_vld = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_down_vld", int'(down_vld), 0);
    chk("midrst_up_rdy", int'(up_rdy), 1);
    out0     = n_out;
    lat_on   = 1'b1;
    up_vld   = 1'b1;
    up_data  = 8'h96;
    up_shamt = 4'd3;
    up_mode  = 1'b1;
    tick();
    chk("post_rst_accept", int'(acc_now), 1);
    drain();
    chk("post_rst_out_count", n_out - out0, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
